// File: rtl/piano_poly_synth.sv
// Polyphonic square-wave tone generator: CHANNELS voices with per-voice pitch,
// timed/sustained mode and ms countdown, PWM-mixed onto one speaker pin.
module piano_poly_synth #(
    parameter int CHANNELS = 4,
    parameter int TONE_DIV = 8,
    parameter int MS_DIV   = 100000
) (
    input  logic                iFpgaClock,
    input  logic                iCpuReset,
    input  logic                iDoPianoWrite,
    input  logic [31:0]         iPianoDataToWrite,
    output logic [CHANNELS-1:0] oPianoBusy,
    output logic                oFpgaSpeaker
);

    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int MW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = $clog2(CHANNELS + 1);

    typedef enum logic [1:0] {V_IDLE, V_TIMED, V_SUSTAIN} voice_state_e;
    typedef enum logic [1:0] {
        OP_STOP     = 2'b00,
        OP_TIMED    = 2'b01,
        OP_SUSTAIN  = 2'b10,
        OP_STOP_ALL = 2'b11
    } op_e;

    logic [3:0]  cmd_idx;
    op_e         cmd_op;
    logic [9:0]  cmd_dur;
    logic [15:0] cmd_half;

    assign cmd_idx  = iPianoDataToWrite[31:28];
    assign cmd_op   = op_e'(iPianoDataToWrite[27:26]);
    assign cmd_dur  = iPianoDataToWrite[25:16];
    assign cmd_half = iPianoDataToWrite[15:0];

    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic [MW-1:0] ms_cnt_q, ms_cnt_d;
    logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic          tone_tick, ms_tick;

    voice_state_e  state_q [CHANNELS];
    voice_state_e  state_d [CHANNELS];
    logic [15:0]   half_q  [CHANNELS];
    logic [15:0]   half_d  [CHANNELS];
    logic [15:0]   div_q   [CHANNELS];
    logic [15:0]   div_d   [CHANNELS];
    logic [9:0]    dur_q   [CHANNELS];
    logic [9:0]    dur_d   [CHANNELS];
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] busy_q, busy_d;
    logic [SW-1:0]       active_hi;
    logic                spk_q, spk_d;

    always_comb begin
        tone_tick  = (tone_cnt_q == TW'(TONE_DIV - 1));
        ms_tick    = (ms_cnt_q == MW'(MS_DIV - 1));
        tone_cnt_d = tone_tick ? '0 : tone_cnt_q + TW'(1);
        ms_cnt_d   = ms_tick ? '0 : ms_cnt_q + MW'(1);
        pwm_cnt_d  = (pwm_cnt_q == PW'(CHANNELS - 1)) ? '0 : pwm_cnt_q + PW'(1);
    end

    // An index at or above CHANNELS matches no k, which makes it a no-op.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            sel[k] = iDoPianoWrite && (cmd_op != OP_STOP_ALL) && (cmd_idx == 4'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
            state_d[k] = state_q[k];
            half_d[k]  = half_q[k];
            div_d[k]   = div_q[k];
            dur_d[k]   = dur_q[k];
            phase_d[k] = phase_q[k];

            if (iDoPianoWrite && cmd_op == OP_STOP_ALL) begin
                state_d[k] = V_IDLE;
                div_d[k]   = '0;
                phase_d[k] = 1'b0;
            end else if (sel[k]) begin
                // A command always overrides same-cycle expiry or tone ticks.
                half_d[k]  = cmd_half;
                div_d[k]   = '0;
                phase_d[k] = 1'b0;
                dur_d[k]   = cmd_dur;
                unique case (cmd_op)
                    OP_TIMED:   state_d[k] = (cmd_dur != '0) ? V_TIMED : V_IDLE;
                    OP_SUSTAIN: state_d[k] = V_SUSTAIN;
                    default:    state_d[k] = V_IDLE;
                endcase
            end else if (state_q[k] != V_IDLE) begin
                if (tone_tick && half_q[k] != '0) begin
                    if (div_q[k] == half_q[k] - 16'd1) begin
                        div_d[k]   = '0;
                        phase_d[k] = ~phase_q[k];
                    end else begin
                        div_d[k] = div_q[k] + 16'd1;
                    end
                end
                if (state_q[k] == V_TIMED && ms_tick) begin
                    if (dur_q[k] == 10'd1) begin
                        state_d[k] = V_IDLE;
                        div_d[k]   = '0;
                        phase_d[k] = 1'b0;
                    end else begin
                        dur_d[k] = dur_q[k] - 10'd1;
                    end
                end
            end
            busy_d[k] = (state_d[k] != V_IDLE);
        end
    end

    always_comb begin
        active_hi = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            active_hi = active_hi + SW'((state_q[k] != V_IDLE) && phase_q[k]);
        end
        spk_d = (SW'(pwm_cnt_q) < active_hi);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iFpgaClock) begin
        if (iCpuReset) begin
            tone_cnt_q <= '0;
            ms_cnt_q   <= '0;
            pwm_cnt_q  <= '0;
            phase_q    <= '0;
            busy_q     <= '0;
            spk_q      <= 1'b0;
            // NOTE: the per-voice arrays are reset because a reset must silence notes and drop countdowns.
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= V_IDLE;
                half_q[k]  <= '0;
                div_q[k]   <= '0;
                dur_q[k]   <= '0;
            end
        end else begin
            tone_cnt_q <= tone_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            spk_q      <= spk_d;
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= state_d[k];
                half_q[k]  <= half_d[k];
                div_q[k]   <= div_d[k];
                dur_q[k]   <= dur_d[k];
            end
        end
    end

    assign oPianoBusy   = busy_q;
    assign oFpgaSpeaker = spk_q;

endmodule

// File: tb/tb_piano_poly_synth.sv
// Self-checking bench for piano_poly_synth: directed scenarios plus random
// commands, compared every clock against a time-based reference model.
module tb_piano_poly_synth;

    localparam int CH = 4;
    localparam int TD = 1;
    localparam int MD = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0;
    logic [31:0]   word = '0;
    logic [CH-1:0] busy;
    logic          spk;

    always #5 clk = ~clk;

    piano_poly_synth #(.CHANNELS(CH), .TONE_DIV(TD), .MS_DIV(MD)) dut (
        .iFpgaClock       (clk),
        .iCpuReset        (rst),
        .iDoPianoWrite    (wr),
        .iPianoDataToWrite(word),
        .oPianoBusy       (busy),
        .oFpgaSpeaker     (spk)
    );

    // Model: each voice is a record (start edge, half period, end edge); the
    // state at edge e is derived arithmetically. Edges count from reset.
    int  e_cnt;
    bit  act [CH];
    bit  sus [CH];
    int  st  [CH];
    int  ex  [CH];
    int  hh  [CH];
    int  s_prev;
    bit  last_exp_spk;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, e_cnt);
        end
    endtask

    function automatic bit m_busy(input int v, input int e);
        return act[v] && (sus[v] || e < ex[v]);
    endfunction

    function automatic bit m_phase(input int v, input int e);
        if (hh[v] == 0) return 1'b0;
        return bit'(((e - st[v]) / hh[v]) % 2);
    endfunction

    function automatic int m_sum(input int e);
        int s = 0;
        for (int v = 0; v < CH; v++) if (m_busy(v, e) && m_phase(v, e)) s++;
        return s;
    endfunction

    function automatic logic [31:0] cmd(input int idx, input int op, input int d, input int h);
        return {4'(idx), 2'(op), 10'(d), 16'(h)};
    endfunction

    task automatic model_write(input logic [31:0] w);
        int idx = int'(w[31:28]);
        int op  = int'(w[27:26]);
        int d   = int'(w[25:16]);
        int h   = int'(w[15:0]);
        if (op == 3) begin
            for (int v = 0; v < CH; v++) act[v] = 1'b0;
        end else if (idx < CH) begin
            if (op == 0 || (op == 1 && d == 0)) begin
                act[idx] = 1'b0;
            end else begin
                act[idx] = 1'b1;
                sus[idx] = (op == 2);
                st[idx]  = e_cnt;
                hh[idx]  = h;
                // ms ticks land on edges that are multiples of MD; the write edge's own tick is lost.
                ex[idx]  = ((e_cnt / MD) + 1) * MD + (d - 1) * MD;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [31:0] d);
        logic [CH-1:0] exp_busy;
        rst  = r;
        wr   = w;
        word = d;
        @(posedge clk);
        #1;
        if (r) begin
            e_cnt = 0;
            for (int v = 0; v < CH; v++) act[v] = 1'b0;
            s_prev = 0;
            last_exp_spk = 1'b0;
        end else begin
            last_exp_spk = ((e_cnt % CH) < s_prev);
            e_cnt++;
            if (w) model_write(d);
            s_prev = m_sum(e_cnt);
        end
        for (int v = 0; v < CH; v++) exp_busy[v] = m_busy(v, e_cnt);
        check("busy", busy, exp_busy);
        check("speaker", spk, last_exp_spk);
        rst = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int w_edge;
        int k;
        int hi;
        int exp_hi;
        int target;
        logic [CH-1:0] snap;

        // Reset with a live write strobe: the command must not be taken.
        cycle(1'b1, 1'b1, 32'h0400_0003);
        cycle(1'b1, 1'b1, 32'h0400_0003);
        idle(2);
        check("reset_busy", busy, 4'b0000);
        check("reset_speaker", spk, 1'b0);

        // Timed tone ch0, D=5, H=3.
        cycle(1'b0, 1'b1, cmd(0, 1, 5, 3));
        w_edge = e_cnt;
        check("timed_busy_next_clk", busy[0], 1'b1);
        k = 0;
        while (busy[0] && k < 60) begin
            idle(1);
            k++;
        end
        check("timed_len_window", (e_cnt - w_edge >= 40) && (e_cnt - w_edge <= 50), 1'b1);
        check("timed_fall_edge", e_cnt, ex[0]);

        // Two sustained voices, H=4, plus tally of speaker high time.
        cycle(1'b0, 1'b1, cmd(0, 2, 0, 4));
        cycle(1'b0, 1'b1, cmd(1, 2, 0, 4));
        hi = 0;
        exp_hi = 0;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            hi += int'(spk);
            exp_hi += int'(last_exp_spk);
        end
        check("mix_hi_count", hi, exp_hi);
        cycle(1'b0, 1'b1, cmd(0, 3, 0, 0));
        idle(2);

        // Boundaries: D=0, rest H=0, out-of-range index.
        cycle(1'b0, 1'b1, cmd(2, 1, 0, 3));
        idle(3);
        check("d0_stays_idle", busy[2], 1'b0);
        cycle(1'b0, 1'b1, cmd(3, 2, 9, 0));
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            idle(1);
            hi += int'(spk);
        end
        check("rest_busy", busy[3], 1'b1);
        check("rest_silent", hi, 0);
        snap = busy;
        cycle(1'b0, 1'b1, cmd(7, 1, 5, 2));
        idle(2);
        check("bad_index_noop", busy, snap);
        cycle(1'b0, 1'b1, cmd(9, 3, 0, 0));
        idle(2);
        check("stop_all_ignores_idx", busy, 4'b0000);

        // Retrigger in the exact expiry cycle.
        cycle(1'b0, 1'b1, cmd(0, 1, 1, 2));
        target = ex[0];
        k = 0;
        while (e_cnt + 1 < target && k < 20) begin
            idle(1);
            k++;
        end
        cycle(1'b0, 1'b1, cmd(0, 1, 3, 2));
        check("retrig_busy", busy[0], 1'b1);
        k = 0;
        while (busy[0] && k < 50) begin
            idle(1);
            k++;
        end
        check("retrig_fall_edge", e_cnt, target + 3 * MD);

        // Stop all, then reset mid-note.
        cycle(1'b0, 1'b1, cmd(0, 2, 0, 2));
        cycle(1'b0, 1'b1, cmd(1, 2, 0, 3));
        cycle(1'b0, 1'b1, cmd(2, 1, 20, 1));
        idle(6);
        check("three_busy", busy, 4'b0111);
        cycle(1'b0, 1'b1, cmd(1, 3, 0, 0));
        idle(1);
        check("stop_all_busy", busy, 4'b0000);
        check("stop_all_speaker", spk, 1'b0);
        cycle(1'b0, 1'b1, cmd(0, 2, 0, 2));
        cycle(1'b0, 1'b1, cmd(1, 2, 0, 3));
        cycle(1'b0, 1'b1, cmd(2, 1, 20, 1));
        idle(5);
        cycle(1'b1, 1'b0, 32'h0);
        check("reset_mid_busy", busy, 4'b0000);
        check("reset_mid_speaker", spk, 1'b0);
        idle(2);

        // Random command stream.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                cycle(1'b1, 1'b0, 32'h0);
            end else if ($urandom_range(0, 5) == 0) begin
                cycle(1'b0, 1'b1, cmd(int'($urandom_range(0, 7)),
                                      (($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2))),
                                      int'($urandom_range(0, 4)),
                                      int'($urandom_range(0, 6))));
            end else begin
                cycle(1'b0, ($urandom_range(0, 19) == 0), $urandom());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
